input_skew_buffer: RTL
======================

# input_skew_buffer

Parametrised successor to the fixed 32-lane input array: buffers column vectors of activations in a shared multi-lane FIFO and replays a tile of rows into the systolic array. Lane i is delayed by i cycles, producing the diagonal wavefront the PE grid expects. It adds start/done tiling, output back-pressure, a skew-bypass mode and full/empty flow control. It sits between the activation loader and the PE array's west edge.

## Interface
- DATA_W, 16, word width per lane
- LANES, 32, lane count (≥2); skew depth is LANES-1
- DEPTH, 64, rows held (power of two)
- CNT_W, $clog2(DEPTH+1), occupancy / tile-length width
---
- clk  in  1  clock; all logic on rising edge
- nrst  in  1  reset, asynchronous, active-low
- in_vld  in  1  write row valid
- in_rdy  out  1  = !full
- in_data  in  [DATA_W-1:0][LANES]  one word per lane
- start  in  1  begin tile replay; accepted when start & start_rdy
- start_rdy  out  1  state==IDLE && tile_len!=0 && tile_len≤count
- tile_len  in  CNT_W  rows to replay, sampled on start accept
- skew_en  in  1  1 = diagonal skew, 0 = all lanes aligned; sampled on start accept
- out_stall  in  1  array back-pressure; freezes the replay pipeline
- data_out  out  [DATA_W-1:0][LANES]  per-lane output word
- out_vld  out  [LANES-1:0]  per-lane valid
- busy  out  1  state!=IDLE
- done  out  1  single-cycle tile-complete pulse
- count  out  CNT_W  rows stored
- full, empty  out  1  count==DEPTH / count==0

## Operation
- Push: in_vld & in_rdy writes all lanes into row wptr; wptr wraps modulo DEPTH.
- FSM IDLE→RUN on start accept: latch tile_len into rows_left and skew_en into skew_q.
- RUN: each non-stalled cycle pops row rptr into lane stage 0 and decrements rows_left; after the last pop go to DRAIN if skew_q, else straight to IDLE with done.
- DRAIN: LANES-1 non-stalled cycles flush the skew lines; then done and IDLE.
- Lane i output = stage-0 row delayed i non-stalled cycles (skew_q=1) or 0 cycles (skew_q=0).
- Simultaneous push and pop: count unchanged; a push while full is refused (in_rdy=0) even if a pop occurs that cycle.
- start outside IDLE, or with tile_len=0 or tile_len>count, is ignored (no error state).
- out_stall=1: no pop, delay lines and outputs hold, FSM counters hold; pushes continue.

## Timing
- Reset values: data_out=0, out_vld=0, done=0, busy=0, count=0, empty=1, full=0, in_rdy=1, start_rdy=0, pointers 0, state IDLE.
- Reset mid-tile: immediate return to reset values; stored rows discarded.
- No stalls, start accepted at edge E: row k on lane i is valid in the cycle after edge E+1+k+i (skew) or E+1+k (bypass).
- Tile length in cycles: tile_len+LANES-1 (skew) or tile_len (bypass); each stall cycle adds one.
- done is high in the cycle the last lane shows its last row; start_rdy may go high the next cycle.
- count updates one cycle after the push/pop edge; full/empty/in_rdy are derived from registered count.

## Structure
- Package cnn_buf_pkg: state enum {IDLE, RUN, DRAIN}, default DATA_W/LANES/DEPTH constants, lane-vector typedef.
- Sub-module skew_delay_line (params DATA_W, DELAY): enable-gated shift register carrying {vld,data}; DELAY=0 is a wire. Instantiate per lane with DELAY=i, muxed by skew_q.

## Test plan
- Reset with in_vld=1: all outputs at reset values; release nrst, push 4 rows -> count=4 one cycle after the 4th push edge.
- LANES=32, push rows with lane value 100*row+lane, tile_len=4, skew_en=1 -> lane 5 shows 5,105,205,305 in cycles E+7..E+10; done at E+36; count=0.
- Same data, skew_en=0 -> all lanes valid in cycles E+2..E+5; done at E+5.
- Fill DEPTH=64 rows -> full=1, in_rdy=0; extra push is refused; start with tile_len=64 while pushing -> no data lost and count stays at ≤64.
- out_stall held 3 cycles mid-RUN -> outputs frozen, done delayed exactly 3 cycles, data order intact.
- start with tile_len=0, and start with tile_len=5 while count=3 -> ignored, busy stays 0; nrst pulse mid-DRAIN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/cnn_buf_pkg.sv
// rtl/cnn_buf_pkg.sv - shared types and defaults for the input skew buffer
package cnn_buf_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_LANES  = 32;
    localparam int DEF_DEPTH  = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // One row of activations: one word per lane at the default geometry
    typedef logic [DEF_LANES-1:0][DEF_DATA_W-1:0] lane_vec_t;

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - enable-gated {vld,data} delay line, DELAY=0 is a wire
module skew_delay_line #(
    parameter int DATA_W = 16,
    parameter int DELAY  = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              din_vld,
    input  logic [DATA_W-1:0] din,
    output logic              dout_vld,
    output logic [DATA_W-1:0] dout
);

    generate
        if (DELAY == 0) begin : g_wire
            // Lane 0 has no skew; clock, reset and enable are not needed
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, nrst, en};
            assign dout_vld    = din_vld;
            assign dout        = din;
        end else begin : g_shift
            logic [DELAY-1:0][DATA_W:0] sr;

            // Shift {vld,data} one stage per non-stalled cycle
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    sr <= '0;
                end else if (en) begin
                    sr[0] <= {din_vld, din};
                    for (int j = 1; j < DELAY; j++) begin
                        sr[j] <= sr[j-1];
                    end
                end
            end

            assign {dout_vld, dout} = sr[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/input_skew_buffer.sv
// rtl/input_skew_buffer.sv - row FIFO with tiled, optionally skewed replay to the PE array
module input_skew_buffer
    import cnn_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           in_vld,
    output logic                           in_rdy,
    input  logic [LANES-1:0][DATA_W-1:0]   in_data,
    input  logic                           start,
    output logic                           start_rdy,
    input  logic [CNT_W-1:0]               tile_len,
    input  logic                           skew_en,
    input  logic                           out_stall,
    output logic [LANES-1:0][DATA_W-1:0]   data_out,
    output logic [LANES-1:0]               out_vld,
    output logic                           busy,
    output logic                           done,
    output logic [CNT_W-1:0]               count,
    output logic                           full,
    output logic                           empty
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int DRAIN_W = $clog2(LANES);

    logic [LANES-1:0][DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]             wptr;
    logic [PTR_W-1:0]             rptr;
    state_t                       state;
    logic [CNT_W-1:0]             rows_left;
    logic [DRAIN_W-1:0]           drain_cnt;
    logic                         skew_q;
    logic [LANES-1:0][DATA_W-1:0] st0_data;
    logic                         st0_vld;
    logic                         st0_skew;
    logic                         push;
    logic                         pop;
    logic                         start_ok;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign in_rdy    = ~full;
    assign busy      = (state != IDLE);
    assign start_rdy = (state == IDLE) && (tile_len != '0) && (tile_len <= count);
    assign start_ok  = start & start_rdy;
    // A push is decided on registered fullness, so a same-cycle pop never frees a slot
    assign push      = in_vld & ~full;
    assign pop       = (state == RUN) & ~out_stall;

    // Row storage; contents need no reset because pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_data;
        end
    end

    // Write/read pointers and occupancy
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Stage 0: the popped row, tagged with the tile's skew mode so that
    // bypass rows never leak into the skew lines of a following skew tile
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            st0_data <= '0;
            st0_vld  <= 1'b0;
            st0_skew <= 1'b0;
        end else if (!out_stall) begin
            st0_vld  <= pop;
            st0_skew <= skew_q;
            if (pop) st0_data <= mem[rptr];
        end
    end

    // Tile sequencer: IDLE -> RUN (pop tile_len rows) -> DRAIN (flush skew) -> IDLE
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            rows_left <= '0;
            drain_cnt <= '0;
            skew_q    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        rows_left <= tile_len;
                        skew_q    <= skew_en;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (!out_stall) begin
                        rows_left <= rows_left - 1'b1;
                        if (rows_left == CNT_W'(1)) begin
                            if (skew_q) begin
                                state     <= DRAIN;
                                drain_cnt <= DRAIN_W'(LANES - 2);
                            end else begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (!out_stall) begin
                        if (drain_cnt == '0) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic              dl_vld;
            logic [DATA_W-1:0] dl_data;

            skew_delay_line #(
                .DATA_W (DATA_W),
                .DELAY  (i)
            ) u_delay (
                .clk      (clk),
                .nrst     (nrst),
                .en       (~out_stall),
                .din_vld  (st0_vld & st0_skew),
                .din      (st0_data[i]),
                .dout_vld (dl_vld),
                .dout     (dl_data)
            );

            assign out_vld[i]  = skew_q ? dl_vld  : st0_vld;
            assign data_out[i] = skew_q ? dl_data : st0_data[i];
        end
    endgenerate

endmodule
